icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_pkg.sv | 17 +
 rtl/icache_array.sv | 47 ++++
 rtl/icache_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller.
package icache_ctrl_pkg;

    localparam int CACHE_LINES = 8;
    localparam int CACHE_TAG_W = 11;
    localparam int LINE_W      = 64;
    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int LADDR_W     = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port and one synchronous write port. Only the valid bits are reset.
module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int LINES = CACHE_LINES,
    parameter int TAG_W = CACHE_TAG_W,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [LINE_W-1:0] lines [LINES];

    // Valid bits alone gate hits, so they are the only reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data install; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: hit detection, a
// single outstanding line fill from main memory, and word selection.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int LINES = CACHE_LINES,
    parameter int TAG_W = CACHE_TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [WORD_W-1:0]   instr,
    output logic                i_rdy,
    output logic                mem_re,
    output logic [LADDR_W-1:0]  mem_addr,
    input  logic                mem_rdy,
    input  logic [LINE_W-1:0]   mem_rd_data
);

    localparam int IDX_W = $clog2(LINES);

    state_t              state;
    state_t              state_next;
    logic [LADDR_W-1:0]  miss_addr;
    logic [LINE_W-1:0]   fill_data;

    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_data;
    logic                hit;

    assign index = i_addr[IDX_W+1:2];
    assign tag   = i_addr[ADDR_W-1:IDX_W+2];

    icache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (state == WRITE),
        .wr_index (miss_addr[IDX_W-1:0]),
        .wr_tag   (miss_addr[LADDR_W-1:IDX_W]),
        .wr_data  (fill_data)
    );

    assign hit      = rd_valid && (rd_tag == tag);
    assign mem_addr = miss_addr;

    // FSM state register; reset abandons any fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the missing line address and capture the returned fill line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_addr <= '0;
            fill_data <= '0;
        end else begin
            if (state == IDLE && !hit) begin
                miss_addr <= i_addr[ADDR_W-1:2];
            end
            if (state == FILL && mem_rdy) begin
                fill_data <= mem_rd_data;
            end
        end
    end

    // Next-state logic, hit response with word select, and fill request.
    always_comb begin
        state_next = state;
        i_rdy      = 1'b0;
        instr      = '0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    i_rdy = 1'b1;
                    case (i_addr[1:0])
                        2'd0:    instr = rd_data[15:0];
                        2'd1:    instr = rd_data[31:16];
                        2'd2:    instr = rd_data[47:32];
                        default: instr = rd_data[63:48];
                    endcase
                end else begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_re = 1'b1;
                if (mem_rdy) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
